imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Boot loader that writes the instruction memory from a byte stream (UART RX or debug link).
//  Parses a framed image, packs little-endian bytes into 32-bit words and drives the memory's
//  write port (en/address/data_in).
//  Holds the core in reset (cpu_hold) while an image is loading.
// PARAMETERS
//  SYNC_BYTE     8'hA5  frame start marker
//  TIMEOUT       16'd50000  max idle clk cycles between bytes inside a frame before abort
//  HOLD_AT_RESET 1'b0   1: cpu_hold=1 out of reset until first frame completes
// PORTS
//  clk        in   1   system clock, all logic on posedge
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   byte stream valid
//  in_data    in   8   byte stream data
//  in_ready   out  1   loader accepts byte; transfer when in_valid&in_ready
//  mem_en     out  1   one-cycle write strobe to instruction memory
//  mem_addr   out  8   word address
//  mem_wdata  out  32  word to write
//  cpu_hold   out  1   keep core in reset while 1
//  busy       out  1   frame in progress (state != IDLE)
//  done       out  1   one-cycle pulse, image written successfully
//  err        out  1   one-cycle pulse, frame aborted (timeout or checksum)
// BEHAVIOUR
//  Reset: state=IDLE, mem_en=0, mem_addr=0, mem_wdata=0, in_ready=1, busy=0, done=0, err=0,
//   cpu_hold=HOLD_AT_RESET; internal byte count, word count, timer cleared.
//  Frame: SYNC_BYTE, N (word count; 0 means 256), 4*N payload bytes LSB first [, CKSUM].
//  IDLE: in_ready=1; byte==SYNC_BYTE -> COUNT, cpu_hold<=1; any other byte discarded.
//  COUNT: accept N -> DATA; mem_addr<=0, words_left<=(N==0)?256:N (9-bit).
//  DATA: bytes shift into byte lanes [7:0],[15:8],.. by 2-bit lane counter;
//   on 4th byte: mem_wdata<=word, mem_en=1 in the NEXT cycle (latency 1), exactly 1 cycle.
//   mem_addr increments the cycle after mem_en; 255->0 wrap legal (only when N=0/256).
//   in_ready stays 1 during the mem_en cycle (packing register independent of mem_wdata).
//   After last word's mem_en -> DONE (or CKSUM when enabled).
//  DONE: one cycle; done=1, cpu_hold<=0, in_ready=0 -> IDLE.
//  Timeout: timer resets on every accepted byte; in COUNT/DATA/CKSUM, timer==TIMEOUT ->
//   err=1 for 1 cycle, -> IDLE, cpu_hold stays 1 (partial image); words already written remain.
//  SYNC_BYTE inside DATA is ordinary payload (no resync).
//  Async rst mid-frame: immediate return to reset values; mem_en drops same instant.
//  in_valid with in_ready=0 (DONE cycle): byte not consumed; source holds it.
// CONFIGURATION
//  IMEM_LOADER_CKSUM_EN defined: trailing CKSUM byte required = 8-bit sum mod 256 of
//   N and all payload bytes; match -> DONE; mismatch -> err pulse, cpu_hold stays 1, -> IDLE.
//  Undefined: no CKSUM state; last payload word -> DONE; err only from timeout.
// STRUCTURE
//  Shared package imem_loader_pkg: state encodings (IDLE,COUNT,DATA,CKSUM,DONE),
//   default SYNC_BYTE, IMEM_AW=8, IMEM_DW=32.
//  One sub-module: word_packer (byte-lane shift, lane counter, word_ready strobe).
//  FSM, counters, timer and checksum in top level.
// TESTING
//  1) A5,02,11,22,33,44,55,66,77,88 -> mem_en @addr0 data 44332211, @addr1 88776655; done; hold 1->0.
//  2) Junk 00,FF,A5 then N=01 + 4 bytes -> junk ignored, single write @0, done pulse.
//  3) N=00 with 1024 bytes -> 256 writes addr 0..255, addr wraps to 0, one done.
//  4) Stall TIMEOUT cycles after 2nd payload byte -> err pulse, no mem_en, cpu_hold=1, IDLE.
//  5) rst asserted mid-DATA -> outputs reset values at once; new frame afterwards loads at addr0.
//  6) CKSUM_EN: frame A5,01,01,02,03,04,0B ok -> done; 0C -> err, cpu_hold stays 1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the FSM state encoding, memory geometry and the running-checksum helper.
package imem_loader_pkg;

    localparam int unsigned IMEM_AW = 8;
    localparam int unsigned IMEM_DW = 32;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_CKSUM = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic [7:0] cksum_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master = stream source / memory side, slave = the loader.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               mem_en;
    logic [IMEM_AW-1:0] mem_addr;
    logic [IMEM_DW-1:0] mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_en, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_en, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_loader_word_packer.sv
// Packs little-endian bytes into 32-bit words; the word is presented together
// with the 4th byte so the caller can register it with one cycle of latency.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               word_ready,
    output logic [IMEM_DW-1:0] word
);

    logic [1:0]  lane_r;
    logic [23:0] lanes_r;

    // Lower three lanes collect bytes; the top lane is taken straight from the input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_r  <= 2'd0;
            lanes_r <= 24'd0;
        end else if (clr) begin
            lane_r  <= 2'd0;
            lanes_r <= 24'd0;
        end else if (byte_valid) begin
            lane_r <= lane_r + 2'd1;
            case (lane_r)
                2'd0:    lanes_r[7:0]   <= byte_data;
                2'd1:    lanes_r[15:8]  <= byte_data;
                2'd2:    lanes_r[23:16] <= byte_data;
                default: lanes_r        <= lanes_r;
            endcase
        end
    end

    assign word_ready = byte_valid && (lane_r == 2'd3);
    assign word       = {byte_data, lanes_r};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses SYNC, N, 4*N payload bytes into instruction-memory writes
// and holds the core while loading. Optional trailing checksum: IMEM_LOADER_CKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEF,
    parameter logic [15:0] TIMEOUT       = 16'd50000,
    parameter logic        HOLD_AT_RESET = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         busy,
    output logic         done,
    output logic         err
);

`ifdef IMEM_LOADER_CKSUM_EN
    localparam state_t ST_AFTER_DATA = ST_CKSUM;
`else
    localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

    state_t             state_r;
    state_t             state_s;
    logic               in_ready_s;
    logic               busy_s;
    logic               done_s;
    logic               accept_s;
    logic               timeout_s;
    logic               err_evt_s;
    logic               cksum_bad_s;
    logic               pack_valid_s;
    logic               word_ready_s;
    logic [IMEM_DW-1:0] word_s;

    logic               mem_en_r;
    logic [IMEM_AW-1:0] mem_addr_r;
    logic [IMEM_DW-1:0] mem_wdata_r;
    logic [8:0]         words_left_r;
    logic [15:0]        timer_r;
    logic               cpu_hold_r;
    logic               err_r;

    assign accept_s     = bus.in_valid && in_ready_s;
    assign pack_valid_s = accept_s && (state_r == ST_DATA);
    assign timeout_s    = ((state_r == ST_COUNT) || (state_r == ST_DATA) || (state_r == ST_CKSUM))
                          && (timer_r == TIMEOUT);

`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0] sum_r;

    // Running sum over N and every payload byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r <= 8'd0;
        end else if (accept_s && (state_r == ST_COUNT)) begin
            sum_r <= bus.in_data;
        end else if (pack_valid_s) begin
            sum_r <= cksum_add(sum_r, bus.in_data);
        end
    end

    assign cksum_bad_s = accept_s && (state_r == ST_CKSUM) && (bus.in_data != sum_r);
`else
    assign cksum_bad_s = 1'b0;
`endif

    assign err_evt_s = timeout_s || cksum_bad_s;

    word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (state_r != ST_DATA),
        .byte_valid (pack_valid_s),
        .byte_data  (bus.in_data),
        .word_ready (word_ready_s),
        .word       (word_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a timeout abort takes priority over any byte in flight
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (bus.in_data == SYNC_BYTE)) state_s = ST_COUNT;
                else                                        state_s = ST_IDLE;
            end
            ST_COUNT: begin
                if (timeout_s)     state_s = ST_IDLE;
                else if (accept_s) state_s = ST_DATA;
                else               state_s = ST_COUNT;
            end
            ST_DATA: begin
                if (timeout_s)                   state_s = ST_IDLE;
                else if (words_left_r == 9'd0)   state_s = ST_AFTER_DATA;
                else                             state_s = ST_DATA;
            end
`ifdef IMEM_LOADER_CKSUM_EN
            ST_CKSUM: begin
                if (timeout_s)        state_s = ST_IDLE;
                else if (cksum_bad_s) state_s = ST_IDLE;
                else if (accept_s)    state_s = ST_DONE;
                else                  state_s = ST_CKSUM;
            end
`endif
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State-decoded outputs; DATA stops accepting while the final word is being written
    always_comb begin
        in_ready_s = 1'b0;
        busy_s     = 1'b1;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
            ST_COUNT: in_ready_s = 1'b1;
            ST_DATA:  in_ready_s = (words_left_r != 9'd0);
            ST_CKSUM: in_ready_s = 1'b1;
            ST_DONE:  done_s     = 1'b1;
            default: begin
                in_ready_s = 1'b0;
                busy_s     = 1'b0;
            end
        endcase
    end

    // Write port, word counter, idle timer, core hold and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en_r     <= 1'b0;
            mem_addr_r   <= 8'd0;
            mem_wdata_r  <= 32'd0;
            words_left_r <= 9'd0;
            timer_r      <= 16'd0;
            cpu_hold_r   <= HOLD_AT_RESET;
            err_r        <= 1'b0;
        end else begin
            mem_en_r <= word_ready_s;
            err_r    <= err_evt_s;

            if (word_ready_s) begin
                mem_wdata_r <= word_s;
            end

            if (accept_s && (state_r == ST_COUNT)) begin
                mem_addr_r   <= 8'd0;
                words_left_r <= (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
            end else begin
                if (mem_en_r) begin
                    mem_addr_r <= mem_addr_r + 8'd1;
                end
                if (word_ready_s) begin
                    words_left_r <= words_left_r - 9'd1;
                end
            end

            if (accept_s || (state_r == ST_IDLE) || (state_r == ST_DONE)) begin
                timer_r <= 16'd0;
            end else if (timer_r != TIMEOUT) begin
                timer_r <= timer_r + 16'd1;
            end

            // An aborted frame leaves the hold set: the image in memory is partial
            if ((state_r == ST_IDLE) && accept_s && (bus.in_data == SYNC_BYTE)) begin
                cpu_hold_r <= 1'b1;
            end else if (state_r == ST_DONE) begin
                cpu_hold_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.mem_en    = mem_en_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign cpu_hold      = cpu_hold_r;
    assign busy          = busy_s;
    assign done          = done_s;
    assign err           = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random and directed frames compared against
// expected writes derived from the frame bytes. Checksum cases need IMEM_LOADER_CKSUM_EN.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int TO_I = 300;

    logic clk = 1'b0;
    logic rst;
    logic cpu_hold, busy, done, err;

    imem_loader_if bus ();

    imem_loader #(
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT       (16'(TO_I)),
        .HOLD_AT_RESET (1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          n_done = 0;
    int          n_err  = 0;
    logic [7:0]  frame_q[$];

    // Observe the write port and status pulses away from the active edge
    always @(negedge clk) begin
        if (bus.mem_en === 1'b1) begin
            wa_q.push_back(bus.mem_addr);
            wd_q.push_back(bus.mem_wdata);
        end
        if (done === 1'b1) n_done++;
        if (err === 1'b1)  n_err++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after the byte was taken
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check_val("ready wait", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic append_cksum();
`ifdef IMEM_LOADER_CKSUM_EN
        logic [7:0] s;
        s = 8'd0;
        for (int i = 1; i < frame_q.size(); i++) s = 8'((int'(s) + int'(frame_q[i])) % 256);
        frame_q.push_back(s);
`endif
    endtask

    task automatic set_frame(input int n);
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(n % 256));
        for (int i = 0; i < 4 * n; i++) frame_q.push_back(8'($urandom));
        append_cksum();
    endtask

    task automatic play_frame(input string tag, input bit exp_ok);
        int w0, d0, e0, n, guard;
        w0 = wa_q.size();
        d0 = n_done;
        e0 = n_err;
        n  = (frame_q[1] == 8'd0) ? 256 : int'(frame_q[1]);
        foreach (frame_q[i]) begin
            send_byte(frame_q[i], (n > 16) ? 0 : int'($urandom_range(0, 2)));
            if (i == 1) begin
                check_val($sformatf("%s hold in frame", tag), {31'd0, cpu_hold}, 32'd1);
                check_val($sformatf("%s busy in frame", tag), {31'd0, busy}, 32'd1);
            end
        end
        guard = 0;
        while (n_done == d0 && n_err == e0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check_val($sformatf("%s done pulses", tag), n_done - d0, exp_ok ? 32'd1 : 32'd0);
        check_val($sformatf("%s err pulses", tag), n_err - e0, exp_ok ? 32'd0 : 32'd1);
        check_val($sformatf("%s write count", tag), wa_q.size() - w0, n);
        for (int i = 0; i < n && (w0 + i) < wa_q.size(); i++) begin
            check_val($sformatf("%s addr[%0d]", tag, i), {24'd0, wa_q[w0 + i]}, i % 256);
            check_val($sformatf("%s data[%0d]", tag, i), wd_q[w0 + i],
                      {frame_q[4*i+5], frame_q[4*i+4], frame_q[4*i+3], frame_q[4*i+2]});
        end
        check_val($sformatf("%s hold after", tag), {31'd0, cpu_hold}, exp_ok ? 32'd0 : 32'd1);
        check_val($sformatf("%s busy after", tag), {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int e0, w0, guard;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        repeat (3) @(negedge clk);
        check_val("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_val("rst mem_en", {31'd0, bus.mem_en}, 32'd0);
        check_val("rst mem_addr", {24'd0, bus.mem_addr}, 32'd0);
        check_val("rst mem_wdata", bus.mem_wdata, 32'd0);
        check_val("rst busy", {31'd0, busy}, 32'd0);
        check_val("rst done/err", {30'd0, done, err}, 32'd0);
        check_val("rst cpu_hold", {31'd0, cpu_hold}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed two-word image
        frame_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        append_cksum();
        play_frame("two_words", 1'b1);

        // Junk before sync is discarded
        send_byte(8'h00, 1);
        send_byte(8'hFF, 1);
        check_val("junk busy", {31'd0, busy}, 32'd0);
        set_frame(1);
        play_frame("after_junk", 1'b1);

        for (int k = 0; k < 6; k++) begin
            set_frame(int'($urandom_range(1, 8)));
            play_frame($sformatf("rand%0d", k), 1'b1);
        end

        // N=0 loads 256 words and the address wraps
        set_frame(256);
        play_frame("n256", 1'b1);
        check_val("n256 addr wrap", {24'd0, bus.mem_addr}, 32'd0);

        // Stall after the second payload byte
        e0 = n_err;
        w0 = wa_q.size();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'($urandom), 0);
        send_byte(8'($urandom), 0);
        guard = 0;
        while (n_err == e0 && guard < TO_I + 50) begin
            @(negedge clk);
            guard++;
        end
        check_val("timeout err", n_err - e0, 32'd1);
        check_val("timeout latency", {31'd0, (guard >= TO_I - 2) && (guard <= TO_I + 4)}, 32'd1);
        check_val("timeout no write", wa_q.size() - w0, 32'd0);
        check_val("timeout hold", {31'd0, cpu_hold}, 32'd1);
        check_val("timeout busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);

        set_frame(3);
        play_frame("after_timeout", 1'b1);

        // Asynchronous reset while a write strobe is active
        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
        check_val("pre-rst mem_en", {31'd0, bus.mem_en}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("mid rst mem_en", {31'd0, bus.mem_en}, 32'd0);
        check_val("mid rst busy", {31'd0, busy}, 32'd0);
        check_val("mid rst in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_val("mid rst hold", {31'd0, cpu_hold}, 32'd0);
        check_val("mid rst addr", {24'd0, bus.mem_addr}, 32'd0);
        check_val("mid rst wdata", bus.mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_frame(2);
        play_frame("after_rst", 1'b1);

`ifdef IMEM_LOADER_CKSUM_EN
        frame_q = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
        play_frame("cksum_ok", 1'b1);
        frame_q = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0C};
        play_frame("cksum_bad", 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
